// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// controller state encoding and the iterative engine's operating modes.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b00100;
    localparam logic [4:0] OP_MOD = 5'b00101;
    localparam logic [4:0] OP_LSL = 5'b00110;
    localparam logic [4:0] OP_LSR = 5'b00111;
    localparam logic [4:0] OP_ASR = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_XOR = 5'b01100;
    localparam logic [4:0] OP_NOT = 5'b01101;
    localparam logic [4:0] OP_INC = 5'b01110;
    localparam logic [4:0] OP_DEC = 5'b01111;
    localparam logic [4:0] OP_CMP = 5'b10000;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_ITER} state_t;

    typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_MOD} md_mode_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative signed multiply / divide / modulo engine: works on operand
// magnitudes for W cycles, then applies the sign fix-up combinationally.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  md_mode_t     mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         finish,
    output logic [W-1:0] result,
    output logic         ovf
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    md_mode_t       mode_q;
    logic           neg_q;
    logic           sign_a_q;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [W-1:0]   mag_b;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mag_a_in;
    logic [W-1:0]   mag_b_in;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s;
    logic [W-1:0]   rem_s;

    assign mag_a_in = a[W-1] ? -a : a;
    assign mag_b_in = b[W-1] ? -b : b;

    // hi is kept below mag_b while dividing, so a set bit W in the difference means "does not fit".
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {hi, lo[W-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
    assign quo_s  = neg_q ? -lo : lo;
    assign rem_s  = sign_a_q ? -hi : hi;

    always_comb begin
        result = prod_s[W-1:0];
        ovf    = 1'b0;
        case (mode_q)
            MD_MUL: begin
                result = prod_s[W-1:0];
                ovf    = !((&prod_s[2*W-1:W-1]) || !(|prod_s[2*W-1:W-1]));
            end
            MD_DIV: begin
                result = quo_s;
                ovf    = !neg_q && lo[W-1];
            end
            MD_MOD: begin
                result = rem_s;
                ovf    = 1'b0;
            end
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MD_MUL;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            finish   <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (start) begin
                mode_q   <= mode;
                neg_q    <= a[W-1] ^ b[W-1];
                sign_a_q <= a[W-1];
                hi       <= '0;
                lo       <= mag_a_in;
                mag_b    <= mag_b_in;
                cnt      <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                if (mode_q == MD_MUL) begin
                    hi <= mul_sum[W:1];
                    lo <= {mul_sum[0], lo[W-1:1]};
                end else begin
                    hi <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
                    lo <= {lo[W-2:0], ~div_diff[W]};
                end
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy   <= 1'b0;
                    finish <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: request handshake FSM, single-cycle datapath, flag
// generation and the result accumulator; MUL/DIV/MOD go to the iterative engine.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic [4:0]   alu_op,
    input  logic         use_acc,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags,
    output logic         done
);
    state_t          state;
    state_t          state_next;
    logic [4:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    a_in;
    logic            accept;
    logic            iter_req;
    logic            md_start;
    logic            fin_exec;
    logic            fin_iter;
    md_mode_t        md_mode;
    logic            md_busy;
    logic            md_finish;
    logic            md_ovf;
    logic [W-1:0]    md_result;
    logic [W-1:0]    y;
    logic            cin;
    logic [W:0]      sum;
    logic [SW-1:0]   amt;
    logic [W:0]      lsl_ext;
    logic [W:0]      lsr_ext;
    logic signed [W:0] asr_ext;
    logic [W-1:0]    exec_res;
    logic            exec_c;
    logic            exec_v;
    logic            exec_wr_acc;
    logic            exec_wr_flags;

    assign ready    = (state == ST_IDLE) && !md_busy;
    assign accept   = start && ready;
    assign a_in     = use_acc ? resultAccumulator : operandA;
    assign iter_req = (alu_op == OP_MUL) ||
                      (((alu_op == OP_DIV) || (alu_op == OP_MOD)) && (operandB != '0));
    assign md_mode  = (alu_op == OP_MUL) ? MD_MUL : ((alu_op == OP_DIV) ? MD_DIV : MD_MOD);

    alu_seq_muldiv #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .mode   (md_mode),
        .a      (a_in),
        .b      (operandB),
        .busy   (md_busy),
        .finish (md_finish),
        .result (md_result),
        .ovf    (md_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        md_start   = 1'b0;
        fin_exec   = 1'b0;
        fin_iter   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = iter_req ? ST_ITER : ST_EXEC;
                    md_start   = iter_req;
                end
            end
            ST_EXEC: begin
                state_next = ST_IDLE;
                fin_exec   = 1'b1;
            end
            ST_ITER: begin
                if (md_finish) begin
                    state_next = ST_IDLE;
                    fin_iter   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One adder covers ADD/SUB/CMP/INC/DEC; subtraction is A + ~B + 1 so C reads as "no borrow".
    always_comb begin
        y   = b_q;
        cin = 1'b0;
        case (op_q)
            OP_SUB, OP_CMP: begin y = ~b_q; cin = 1'b1; end
            OP_INC:         begin y = '0;   cin = 1'b1; end
            OP_DEC:         begin y = '1;   cin = 1'b0; end
            default:        begin y = b_q;  cin = 1'b0; end
        endcase
    end

    assign sum     = {1'b0, a_q} + {1'b0, y} + {{W{1'b0}}, cin};
    assign amt     = b_q[SW-1:0];
    assign lsl_ext = {1'b0, a_q} << amt;
    assign lsr_ext = {a_q, 1'b0} >> amt;
    assign asr_ext = $signed({a_q, 1'b0}) >>> amt;

    always_comb begin
        exec_res      = '0;
        exec_c        = 1'b0;
        exec_v        = 1'b0;
        exec_wr_acc   = 1'b1;
        exec_wr_flags = 1'b1;
        case (op_q)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_CMP: begin
                exec_res    = sum[W-1:0];
                exec_c      = sum[W];
                exec_v      = (a_q[W-1] == y[W-1]) && (sum[W-1] != a_q[W-1]);
                exec_wr_acc = (op_q != OP_CMP);
            end
            OP_DIV, OP_MOD: begin
                exec_res = '1;
                exec_v   = 1'b1;
            end
            OP_LSL: begin exec_res = lsl_ext[W-1:0]; exec_c = lsl_ext[W]; end
            OP_LSR: begin exec_res = lsr_ext[W:1];   exec_c = lsr_ext[0]; end
            OP_ASR: begin exec_res = asr_ext[W:1];   exec_c = asr_ext[0]; end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            OP_NOT: exec_res = ~a_q;
            default: begin
                exec_wr_acc   = 1'b0;
                exec_wr_flags = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q              <= '0;
            a_q               <= '0;
            b_q               <= '0;
            resultAccumulator <= '0;
            flags             <= '0;
            done              <= 1'b0;
        end else begin
            done <= fin_exec || fin_iter;
            if (accept) begin
                op_q <= alu_op;
                a_q  <= a_in;
                b_q  <= operandB;
            end
            if (fin_exec && exec_wr_acc)
                resultAccumulator <= exec_res;
            if (fin_exec && exec_wr_flags)
                flags <= pack_flags(exec_res == '0, exec_res[W-1], exec_c, exec_v);
            if (fin_iter) begin
                resultAccumulator <= md_result;
                flags             <= pack_flags(md_result == '0, md_result[W-1], 1'b0, md_ovf);
            end
        end
    end

endmodule
